// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stage stall requests and MEM-stage redirects in,
// stall vector, flush/redirect target and stall statistics out.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stallreq_id;
  logic             stallreq_ex;
  logic             stallreq_mem;
  logic             excp_valid;
  logic [31:0]      excp_handler;
  logic             eret_valid;
  logic [31:0]      epc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_timeout;

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem,
    output excp_valid, excp_handler, eret_valid, epc,
    input  stall, flush, new_pc, stall_cnt, stall_timeout
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_valid, excp_handler, eret_valid, epc,
    output stall, flush, new_pc, stall_cnt, stall_timeout
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, registered exception/ERET flush
// sequencing, saturating stall counter and sticky stall watchdog.
module pipe_ctrl #(
  parameter int FLUSH_LEN = 1,
  parameter int STALL_MAX = 64,
  parameter int CNT_W     = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);
  localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
  localparam int WW = $clog2(STALL_MAX + 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [FW-1:0]    fcnt, fcnt_nxt;
  logic [31:0]      npc, npc_nxt;
  logic [CNT_W-1:0] scnt;
  logic [WW-1:0]    wd, wd_nxt;
  logic             tout;
  logic             redir;
  logic             sel_mem, sel_ex, sel_id;
  logic [5:0]       stall;

  assign redir   = bus.excp_valid | bus.eret_valid;
  assign sel_mem = bus.stallreq_mem;
  assign sel_ex  = bus.stallreq_ex & ~bus.stallreq_mem;
  assign sel_id  = bus.stallreq_id & ~bus.stallreq_ex
                 & ~bus.stallreq_mem;

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    npc_nxt   = npc;
    stall     = 6'b000000;
    case (state)
      RUN: begin
        if (redir) begin
          state_nxt = FLUSH;
          fcnt_nxt  = FW'(FLUSH_LEN - 1);
          npc_nxt   = bus.excp_valid ? bus.excp_handler
                                     : bus.epc;
        end else begin
          unique case (1'b1)
            sel_mem: stall = 6'b011111;
            sel_ex:  stall = 6'b001111;
            sel_id:  stall = 6'b000111;
            default: stall = 6'b000000;
          endcase
        end
      end
      FLUSH: begin
        if (fcnt == '0) state_nxt = RUN;
        else            fcnt_nxt  = fcnt - FW'(1);
      end
      default: state_nxt = RUN;
    endcase
    // registers downstream sample stall, so reset must mask it too
    if (rst) stall = 6'b000000;
  end

  always_comb begin
    wd_nxt = '0;
    if (state == RUN && stall != 6'b000000) begin
      if (wd == WW'(STALL_MAX)) wd_nxt = wd;
      else                      wd_nxt = wd + WW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      fcnt  <= '0;
      npc   <= '0;
      scnt  <= '0;
      wd    <= '0;
      tout  <= 1'b0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
      npc   <= npc_nxt;
      wd    <= wd_nxt;
      if (stall != 6'b000000 && scnt != '1)
        scnt <= scnt + CNT_W'(1);
      if (wd_nxt == WW'(STALL_MAX))
        tout <= 1'b1;
    end
  end

  assign bus.stall         = stall;
  assign bus.flush         = (state == FLUSH);
  assign bus.new_pc        = npc;
  assign bus.stall_cnt     = scnt;
  assign bus.stall_timeout = tout;
endmodule
